// File: rtl/mux_tree_pkg.sv
// Shared helpers for the pipelined radix-4 selector tree.
package mux_tree_pkg;

  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // One registered level per two select bits; an odd leftover bit gets a radix-2 level.
  function automatic int level_count(input int n);
    return (clog2_f(n) + 1) / 2;
  endfunction

endpackage

// File: rtl/mux4_stage.sv
// One registered tree level: N_IN inputs reduced 4:1 (or 2:1 when N_IN == 2),
// with valid and the full select tag carried alongside the data.
module mux4_stage #(
  parameter int WIDTH = 1,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2,
  parameter int SHIFT = 0,
  localparam int N_OUT = (N_IN >= 4) ? N_IN / 4 : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [SEL_W-1:0]       in_tag,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       out_tag,
  output logic [N_OUT*WIDTH-1:0] out_data
);

  logic [N_OUT*WIDTH-1:0] data_next;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_mux
    if (N_IN == 2) begin : g_r2
      assign data_next[gi*WIDTH +: WIDTH] =
        in_tag[SHIFT] ? in_data[WIDTH +: WIDTH] : in_data[0 +: WIDTH];
    end else begin : g_r4
      logic [1:0]       s;
      logic [WIDTH-1:0] pick;
      assign s = in_tag[SHIFT +: 2];
      always_comb begin
        pick = in_data[(4*gi)*WIDTH +: WIDTH];
        case (s)
          2'd1:    pick = in_data[(4*gi+1)*WIDTH +: WIDTH];
          2'd2:    pick = in_data[(4*gi+2)*WIDTH +: WIDTH];
          2'd3:    pick = in_data[(4*gi+3)*WIDTH +: WIDTH];
          default: pick = in_data[(4*gi)*WIDTH +: WIDTH];
        endcase
      end
      assign data_next[gi*WIDTH +: WIDTH] = pick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_tag   <= in_tag;
      out_data  <= data_next;
    end
  end

endmodule

// File: rtl/mux_tree_scan.sv
// Pipelined NUM_CH:1 selector with channel tagging, manual or auto-scan select,
// and valid/ready flow control where every level stalls together.
module mux_tree_scan
  import mux_tree_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int WIDTH  = 1,
  parameter int SEL_W  = clog2_f(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    scan_en,
  input  logic [SEL_W-1:0]        scan_last,
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int LAT = level_count(NUM_CH);

  logic             adv;
  logic             accept;
  logic [SEL_W-1:0] eff_sel;
  logic [SEL_W-1:0] scan_cnt_reg;
  logic [SEL_W-1:0] scan_cnt_next;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign accept   = in_valid & adv;
  assign eff_sel  = scan_en ? scan_cnt_reg : sel;

  // Wrap uses >= so a scan_last lowered below the count still wraps after one more beat.
  always_comb begin
    scan_cnt_next = scan_cnt_reg;
    if (accept && scan_en) begin
      scan_cnt_next = (scan_cnt_reg >= scan_last) ? '0 : scan_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_reg <= '0;
    end else begin
      scan_cnt_reg <= scan_cnt_next;
    end
  end

  for (genvar gi = 0; gi < LAT; gi++) begin : lvl
    localparam int N_IN  = NUM_CH >> (2 * gi);
    localparam int N_OUT = (N_IN >= 4) ? N_IN / 4 : 1;

    logic [N_IN*WIDTH-1:0]  d_in;
    logic                   v_in;
    logic [SEL_W-1:0]       t_in;
    logic [N_OUT*WIDTH-1:0] d_out;
    logic                   v_out;
    logic [SEL_W-1:0]       t_out;

    if (gi == 0) begin : g_src
      assign d_in = in;
      assign v_in = in_valid;
      assign t_in = eff_sel;
    end else begin : g_chain
      assign d_in = lvl[gi-1].d_out;
      assign v_in = lvl[gi-1].v_out;
      assign t_in = lvl[gi-1].t_out;
    end

    mux4_stage #(
      .WIDTH (WIDTH),
      .N_IN  (N_IN),
      .SEL_W (SEL_W),
      .SHIFT (2 * gi)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (v_in),
      .in_tag    (t_in),
      .in_data   (d_in),
      .out_valid (v_out),
      .out_tag   (t_out),
      .out_data  (d_out)
    );
  end

  assign out       = lvl[LAT-1].d_out;
  assign out_ch    = lvl[LAT-1].t_out;
  assign out_valid = lvl[LAT-1].v_out;

endmodule

// File: doc/mux_tree_scan.md
Name: mux_tree_scan

Overview:
- Parametrised, pipelined NUM_CH-to-1 selector built as a radix-4 tree, with a register after every tree level.
- Each output beat is tagged with the channel it came from.
- Two select modes: manual (sel port) and auto-scan (internal counter walks channels 0..scan_last).
- Used wherever a multiplexed bus must be sampled at full clock rate with valid/ready flow control.

Parameters:
- NUM_CH, 16, channel count; power of 2, 2..256.
- WIDTH, 1, bits per channel.
- SEL_W, $clog2(NUM_CH), select/tag width (derived, do not override).
- LAT, ceil(SEL_W/2), pipeline depth in cycles (derived; 2 for NUM_CH=16).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in  input  NUM_CH*WIDTH  channel data; channel k = in[k*WIDTH +: WIDTH].
- in_valid  input  1  request to sample one beat.
- in_ready  output  1  pipeline can accept this cycle.
- sel  input  SEL_W  manual channel select (used when scan_en=0).
- scan_en  input  1  1 = auto-scan mode.
- scan_last  input  SEL_W  highest channel visited in auto-scan.
- out  output  WIDTH  selected data.
- out_ch  output  SEL_W  channel index of out.
- out_valid  output  1  out/out_ch valid.
- out_ready  input  1  consumer accepts out.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - out = 0, out_ch = 0, out_valid = 0.
  - All pipeline valid bits = 0; scan counter = 0.
  - in_ready = 1 one cycle after release.
- Advance enable: adv = out_ready | ~out_valid. All pipeline stages load only when adv=1; otherwise every stage holds. in_ready = adv (combinational).
- Accept: a beat is accepted when in_valid & in_ready.
- Effective select: eff_sel = scan_en ? scan_cnt : sel, sampled in the accept cycle.
  - Data for all channels is captured in the accept cycle. Later changes to in do not affect the beat.
- Tree:
  - Level i selects with eff_sel bits [2i+1:2i]. If SEL_W is odd, the top level is radix-2.
  - Each level is registered; eff_sel and valid travel with the data.
- Latency: beat accepted in cycle t appears with out_valid=1 in cycle t+LAT, provided adv stays 1.
  - Throughput is 1 beat/cycle.
  - Non-accepted cycles insert bubbles (valid=0).
- Output hold: while out_valid=1 & out_ready=0, out, out_ch and out_valid are stable and no beat is lost or duplicated.
- Scan counter:
  - Increments on each accepted beat when scan_en=1.
  - When scan_cnt >= scan_last it wraps to 0 on the next accept.
  - Holds when scan_en=0.
  - Switching scan_en 1->0->1 resumes from the held value.
  - If scan_last is lowered below scan_cnt, the next accept still samples scan_cnt, then wraps to 0.
- sel out of range: cannot occur (NUM_CH = 2^SEL_W).
- Reset mid-operation: all in-flight beats are discarded and out_valid drops immediately (async).
- Simultaneous output drain and new accept in the same cycle: both happen (full-rate pipeline).

Decomposition:
- Package mux_tree_pkg: clog2 helper function and a level-count function computing LAT from NUM_CH.
- Sub-module mux4_stage: parametrised WIDTH, registered radix-4 select stage with valid, enable and tag pass-through.
  - Tree built with generate loops over mux4_stage.
  - Radix-2 top level when SEL_W is odd is a mode of the same sub-module (upper inputs unused).

Test Plan:
- NUM_CH=16, WIDTH=1, in=16'h0f0f, manual sel=0,1,4,5,8 on consecutive cycles, out_ready=1 -> two cycles later out = 1,1,0,0,1 with out_ch = 0,1,4,5,8 back-to-back.
- Auto-scan, scan_last=3, in_valid held 1 for 10 cycles -> out_ch sequence 0,1,2,3,0,1,2,3,0,1; out matches in bits.
- Backpressure: out_ready=0 for 3 cycles mid-stream -> in_ready=0 for those cycles; out is held stable; no beat is lost or duplicated (scoreboard on out_ch order).
- NUM_CH=8 (odd SEL_W), WIDTH=8, in = channel k holds value 8'hA0+k, sel sweep 0..7 -> LAT=2; out = A0..A7.
- Async rst asserted between clock edges with 2 beats in flight -> out_valid=0 immediately; after release no stale beat emerges; scan_cnt restarts at 0.
- in changed the cycle after accept -> out reflects the value captured at accept.
